// File: rtl/sram_pkg.sv
// Shared types and constants for the async-SRAM burst initiator.
package sram_pkg;

  localparam int SRAM_AW          = 17;
  localparam int SRAM_DW          = 8;
  localparam int SRAM_WAIT_CYCLES = 1;

  typedef enum logic [2:0] {
    IDLE,
    WRIN,
    SETUP,
    STROBE,
    HOLD,
    RDOUT
  } state_t;

endpackage

// File: rtl/sram_master_if.sv
// Async-SRAM bus: active-low chip select, byte enable and strobes, byte-wide data.
interface sram_master_if #(
  parameter int AW = sram_pkg::SRAM_AW,
  parameter int DW = sram_pkg::SRAM_DW
);

  logic          chipselect_n;
  logic          byteenable_n;
  logic          write_n;
  logic          read_n;
  logic [AW-1:0] address;
  logic [DW-1:0] writedata;
  logic [DW-1:0] readdata;

  modport master (
    output chipselect_n, byteenable_n, write_n, read_n, address, writedata,
    input  readdata
  );

  modport slave (
    input  chipselect_n, byteenable_n, write_n, read_n, address, writedata,
    output readdata
  );

endinterface

// File: rtl/sram_master.sv
// Burst sequencer for the async-SRAM bridge: one byte per SETUP/STROBE(WAIT_CYCLES+1)/HOLD access.
// Stalls only in WRIN (no write byte) or RDOUT (read byte not taken); strobes are never held mid-access.
module sram_master
  import sram_pkg::*;
#(
  parameter int AW          = SRAM_AW,
  parameter int DW          = SRAM_DW,
  parameter int WAIT_CYCLES = SRAM_WAIT_CYCLES
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [7:0]    cmd_len,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          done,
  sram_master_if.master m
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  state_t        state;
  logic [AW-1:0] addr;
  logic          is_wr;
  logic [8:0]    count;
  logic [3:0]    wait_cnt;

  assign wr_ready = (state == WRIN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      addr           <= '0;
      is_wr          <= 1'b0;
      count          <= '0;
      wait_cnt       <= '0;
      cmd_ready      <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      rd_valid       <= 1'b0;
      rd_data        <= '0;
      m.chipselect_n <= 1'b1;
      m.byteenable_n <= 1'b1;
      m.write_n      <= 1'b1;
      m.read_n       <= 1'b1;
      m.address      <= '0;
      m.writedata    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            addr      <= cmd_addr;
            is_wr     <= cmd_write;
            count     <= (cmd_len == 8'd0) ? 9'd256 : {1'b0, cmd_len};
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_write) begin
              state <= WRIN;
            end else begin
              state          <= SETUP;
              m.chipselect_n <= 1'b0;
              m.byteenable_n <= 1'b0;
              m.address      <= cmd_addr;
            end
          end
        end

        WRIN: begin
          if (wr_valid) begin
            state          <= SETUP;
            m.writedata    <= wr_data;
            m.chipselect_n <= 1'b0;
            m.byteenable_n <= 1'b0;
            m.address      <= addr;
          end
        end

        SETUP: begin
          state    <= STROBE;
          wait_cnt <= '0;
          if (is_wr) m.write_n <= 1'b0;
          else       m.read_n  <= 1'b0;
        end

        STROBE: begin
          if (wait_cnt == WAIT_LAST) begin
            state     <= HOLD;
            m.write_n <= 1'b1;
            m.read_n  <= 1'b1;
            // Sample at the end of the strobe, after the full access time.
            if (!is_wr) rd_data <= m.readdata;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end

        HOLD: begin
          addr           <= addr + AW'(1);
          count          <= count - 9'd1;
          m.chipselect_n <= 1'b1;
          m.byteenable_n <= 1'b1;
          if (is_wr) begin
            if (count == 9'd1) begin
              state     <= IDLE;
              done      <= 1'b1;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
            end else begin
              state <= WRIN;
            end
          end else begin
            state    <= RDOUT;
            rd_valid <= 1'b1;
          end
        end

        RDOUT: begin
          // count was already decremented in HOLD, so zero means this was the last byte.
          if (rd_ready) begin
            rd_valid <= 1'b0;
            if (count == 9'd0) begin
              state     <= IDLE;
              done      <= 1'b1;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
            end else begin
              state          <= SETUP;
              m.chipselect_n <= 1'b0;
              m.byteenable_n <= 1'b0;
              m.address      <= addr;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_master.sv
// Directed bench for sram_master: WAIT_CYCLES=1 instance on an SRAM model, plus a WAIT_CYCLES=0 instance.
module tb_sram_master;

  logic clk;
  logic reset;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Main instance, WAIT_CYCLES=1
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [16:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [7:0]  wr_data;
  logic        rd_valid, rd_ready;
  logic [7:0]  rd_data;
  logic        busy, done;

  sram_master_if bus ();

  sram_master #(.WAIT_CYCLES(1)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done), .m(bus)
  );

  // Second instance, WAIT_CYCLES=0
  logic        z_cmd_valid, z_cmd_ready, z_cmd_write;
  logic [16:0] z_cmd_addr;
  logic [7:0]  z_cmd_len;
  logic        z_wr_valid, z_wr_ready;
  logic [7:0]  z_wr_data;
  logic        z_rd_valid, z_rd_ready;
  logic [7:0]  z_rd_data;
  logic        z_busy, z_done;

  sram_master_if zbus ();

  sram_master #(.WAIT_CYCLES(0)) dut_z (
    .clk(clk), .reset(reset),
    .cmd_valid(z_cmd_valid), .cmd_ready(z_cmd_ready), .cmd_write(z_cmd_write),
    .cmd_addr(z_cmd_addr), .cmd_len(z_cmd_len),
    .wr_valid(z_wr_valid), .wr_ready(z_wr_ready), .wr_data(z_wr_data),
    .rd_valid(z_rd_valid), .rd_ready(z_rd_ready), .rd_data(z_rd_data),
    .busy(z_busy), .done(z_done), .m(zbus)
  );

  assign zbus.readdata = 8'h00;

  // SRAM model
  logic [7:0] mem [0:(1<<17)-1];

  always @(posedge clk) begin
    if (!bus.chipselect_n && !bus.write_n) mem[bus.address] <= bus.writedata;
  end
  assign bus.readdata = mem[bus.address];

  // Write-byte source: wq_arr[0..wq_n-1] offered in order from wr_base
  logic [7:0] wq_arr [0:255];
  int         wq_n;
  int         wr_base;
  int         wr_idx;
  logic       wr_en;

  initial wr_idx = 0;
  always @(posedge clk) if (wr_valid && wr_ready) wr_idx <= wr_idx + 1;
  assign wr_valid = wr_en && ((wr_idx - wr_base) < wq_n);
  assign wr_data  = wq_arr[8'(wr_idx - wr_base)];

  // Checking
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor, sampled on the falling edge
  int          cyc = 0;
  logic [16:0] wr_addr_q[$], rd_addr_q[$];
  logic [7:0]  wr_dat_q[$], rd_q[$];
  int          wr_len_q[$], rd_len_q[$];
  int          wr_run = 0, rd_run = 0;
  logic        prev_wn = 1'b1, prev_rn = 1'b1;
  int          done_cnt = 0, done_cyc = 0, rd_hs_cyc = 0;
  int          ovl_cnt = 0, stall_viol = 0, stab_viol = 0;
  int          wr_stall_cyc = 0, rd_stall_cyc = 0;
  logic        prev_rd_stall = 1'b0;
  logic [7:0]  prev_rd_data = 8'h00;
  int          z_wstb = 0, z_busy_cnt = 0, z_done_cnt = 0, z_wrin_cnt = 0;
  logic [16:0] z_addr = '0;
  logic [7:0]  z_dat = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (!bus.write_n && !bus.read_n) ovl_cnt++;
    if ((!bus.write_n || !bus.read_n) && bus.chipselect_n) ovl_cnt++;
    if (!bus.write_n) begin
      if (prev_wn) begin
        wr_addr_q.push_back(bus.address);
        wr_dat_q.push_back(bus.writedata);
      end
      wr_run++;
    end else if (wr_run > 0) begin
      wr_len_q.push_back(wr_run);
      wr_run = 0;
    end
    if (!bus.read_n) begin
      if (prev_rn) rd_addr_q.push_back(bus.address);
      rd_run++;
    end else if (rd_run > 0) begin
      rd_len_q.push_back(rd_run);
      rd_run = 0;
    end
    prev_wn = bus.write_n;
    prev_rn = bus.read_n;
    if (wr_ready && !wr_valid) begin
      wr_stall_cyc++;
      if ({bus.chipselect_n, bus.byteenable_n, bus.write_n, bus.read_n} != 4'hF) stall_viol++;
    end
    if (rd_valid && !rd_ready) begin
      rd_stall_cyc++;
      if ({bus.chipselect_n, bus.byteenable_n, bus.write_n, bus.read_n} != 4'hF) stall_viol++;
      if (prev_rd_stall && rd_data !== prev_rd_data) stab_viol++;
    end
    prev_rd_stall = rd_valid && !rd_ready;
    prev_rd_data  = rd_data;
    if (rd_valid && rd_ready) begin
      rd_q.push_back(rd_data);
      rd_hs_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (!zbus.write_n) begin
      z_wstb++;
      z_addr = zbus.address;
      z_dat  = zbus.writedata;
    end
    if (z_busy) z_busy_cnt++;
    if (z_done) z_done_cnt++;
    if (z_wr_ready) z_wrin_cnt++;
  end

  // Stimulus helpers
  int acc_cyc;
  int done_base;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input string tag, input logic w, input logic [16:0] a, input logic [7:0] l);
    int n = 0;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    done_base = done_cnt;
    tick();
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == done_base && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done_once"}, 32'(done_cnt - done_base), 32'd1);
  endtask

  int          b_wa, b_wl, b_rd, b_ra, b_rl, s0, n, bad, dc;
  logic [16:0] a_exp;

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    rd_ready = 1'b0; wr_en = 1'b0; wq_n = 0; wr_base = 0;
    z_cmd_valid = 1'b0; z_cmd_write = 1'b0; z_cmd_addr = '0; z_cmd_len = '0;
    z_wr_valid = 1'b0; z_wr_data = '0; z_rd_ready = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy_done", 32'({busy, done}), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_bus_n", 32'({bus.chipselect_n, bus.byteenable_n, bus.write_n, bus.read_n}), 32'hF);
    check("rst_address", 32'(bus.address), 32'd0);
    check("rst_writedata", 32'(bus.writedata), 32'd0);
    reset = 1'b0;
    tick();

    // Write burst: 3 bytes at 0x10
    wr_base = wr_idx;
    wq_arr[0] = 8'hA1; wq_arr[1] = 8'hB2; wq_arr[2] = 8'hC3; wq_n = 3;
    wr_en = 1'b1;
    b_wa = wr_addr_q.size(); b_wl = wr_len_q.size();
    send_cmd("wr3", 1'b1, 17'h00010, 8'd3);
    wait_done("wr3", 100);
    check("wr3_latency", 32'(done_cyc - acc_cyc), 32'd15);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("wr3_addr%0d", i), 32'(wr_addr_q[b_wa+i]), 32'h10 + 32'(i));
      check($sformatf("wr3_len%0d", i), 32'(wr_len_q[b_wl+i]), 32'd2);
    end
    check("wr3_data0", 32'(wr_dat_q[b_wa]), 32'hA1);
    check("wr3_data1", 32'(wr_dat_q[b_wa+1]), 32'hB2);
    check("wr3_data2", 32'(wr_dat_q[b_wa+2]), 32'hC3);
    wr_en = 1'b0;
    tick();

    // Read burst: 3 bytes back from 0x10
    rd_ready = 1'b1;
    b_rd = rd_q.size(); b_ra = rd_addr_q.size(); b_rl = rd_len_q.size();
    send_cmd("rd3", 1'b0, 17'h00010, 8'd3);
    wait_done("rd3", 100);
    check("rd3_latency", 32'(done_cyc - acc_cyc), 32'd15);
    check("rd3_data0", 32'(rd_q[b_rd]), 32'hA1);
    check("rd3_data1", 32'(rd_q[b_rd+1]), 32'hB2);
    check("rd3_data2", 32'(rd_q[b_rd+2]), 32'hC3);
    check("rd3_addr2", 32'(rd_addr_q[b_ra+2]), 32'h12);
    check("rd3_len1", 32'(rd_len_q[b_rl+1]), 32'd2);
    tick();

    // Wrap, len 0: write 256 bytes from 0x1FFFE, then read them back
    wr_base = wr_idx;
    for (int i = 0; i < 256; i++) wq_arr[i] = 8'(i * 7 + 3);
    wq_n = 256;
    wr_en = 1'b1;
    b_wa = wr_addr_q.size();
    send_cmd("wrap_wr", 1'b1, 17'h1FFFE, 8'd0);
    wait_done("wrap_wr", 1500);
    check("wrap_wr_count", 32'(wr_addr_q.size() - b_wa), 32'd256);
    check("wrap_wr_addr2", 32'(wr_addr_q[b_wa+2]), 32'h00000);
    wr_en = 1'b0;
    tick();
    b_rd = rd_q.size(); b_ra = rd_addr_q.size();
    send_cmd("wrap_rd", 1'b0, 17'h1FFFE, 8'd0);
    wait_done("wrap_rd", 1500);
    check("wrap_rd_count", 32'(rd_q.size() - b_rd), 32'd256);
    check("wrap_rd_addr0", 32'(rd_addr_q[b_ra]), 32'h1FFFE);
    check("wrap_rd_addr1", 32'(rd_addr_q[b_ra+1]), 32'h1FFFF);
    check("wrap_rd_addr2", 32'(rd_addr_q[b_ra+2]), 32'h00000);
    check("wrap_rd_addr255", 32'(rd_addr_q[b_ra+255]), 32'h000FD);
    bad = 0;
    for (int i = 0; i < 256; i++) if (rd_q[b_rd+i] !== wq_arr[i]) bad++;
    check("wrap_rd_data_errs", 32'(bad), 32'd0);
    check("wrap_done_after_hs", 32'(done_cyc - rd_hs_cyc), 32'd1);
    tick();

    // Backpressure: write source drops out mid-burst
    wr_base = wr_idx;
    wq_arr[0] = 8'h11; wq_arr[1] = 8'h22; wq_arr[2] = 8'h33; wq_n = 3;
    wr_en = 1'b1;
    b_wa = wr_addr_q.size();
    s0 = wr_stall_cyc;
    send_cmd("bp_wr", 1'b1, 17'h00040, 8'd3);
    n = 0;
    while ((wr_idx - wr_base) < 1 && n < 20) begin tick(); n++; end
    check("bp_wr_first_byte", 32'(wr_idx - wr_base), 32'd1);
    wr_en = 1'b0;
    n = 0;
    while (!wr_ready && n < 20) begin tick(); n++; end
    check("bp_wr_wrin", 32'(wr_ready), 32'd1);
    repeat (4) tick();
    wr_en = 1'b1;
    wait_done("bp_wr", 100);
    check("bp_wr_stall_seen", 32'((wr_stall_cyc - s0) >= 4), 32'd1);
    check("bp_wr_count", 32'(wr_addr_q.size() - b_wa), 32'd3);
    check("bp_wr_addr1", 32'(wr_addr_q[b_wa+1]), 32'h41);
    check("bp_wr_data1", 32'(wr_dat_q[b_wa+1]), 32'h22);
    check("bp_wr_data2", 32'(wr_dat_q[b_wa+2]), 32'h33);
    wr_en = 1'b0;
    tick();

    // Backpressure: read sink holds off
    rd_ready = 1'b0;
    b_rd = rd_q.size();
    s0 = rd_stall_cyc;
    send_cmd("bp_rd", 1'b0, 17'h00040, 8'd2);
    n = 0;
    while (!rd_valid && n < 20) begin tick(); n++; end
    check("bp_rd_valid", 32'(rd_valid), 32'd1);
    repeat (3) tick();
    rd_ready = 1'b1;
    wait_done("bp_rd", 100);
    check("bp_rd_stall_seen", 32'((rd_stall_cyc - s0) >= 3), 32'd1);
    check("bp_rd_count", 32'(rd_q.size() - b_rd), 32'd2);
    check("bp_rd_data0", 32'(rd_q[b_rd]), 32'h11);
    check("bp_rd_data1", 32'(rd_q[b_rd+1]), 32'h22);
    tick();

    // Reset during the strobe of byte 2 of 4
    wr_base = wr_idx;
    wq_arr[0] = 8'h5A; wq_arr[1] = 8'h6B; wq_arr[2] = 8'h7C; wq_arr[3] = 8'h8D; wq_n = 4;
    wr_en = 1'b1;
    b_wa = wr_addr_q.size();
    dc = done_cnt;
    send_cmd("rst", 1'b1, 17'h00080, 8'd4);
    n = 0;
    while ((wr_addr_q.size() - b_wa) < 2 && n < 40) begin tick(); n++; end
    check("rst_mid_strobe", 32'(bus.write_n), 32'd0);
    reset = 1'b1;
    tick();
    check("rst_mid_bus_n", 32'({bus.chipselect_n, bus.byteenable_n, bus.write_n, bus.read_n}), 32'hF);
    check("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    wr_en = 1'b0;
    repeat (3) tick();
    check("rst_mid_no_done", 32'(done_cnt - dc), 32'd0);
    rd_ready = 1'b1;
    b_rd = rd_q.size();
    send_cmd("rst_after", 1'b0, 17'h00080, 8'd1);
    wait_done("rst_after", 50);
    check("rst_after_data", 32'(rd_q[b_rd]), 32'h5A);
    tick();

    // WAIT_CYCLES=0 instance: single write
    check("z_cmd_ready", 32'(z_cmd_ready), 32'd1);
    z_wr_valid  = 1'b1;
    z_wr_data   = 8'h5A;
    z_cmd_write = 1'b1;
    z_cmd_addr  = 17'h00123;
    z_cmd_len   = 8'd1;
    z_cmd_valid = 1'b1;
    tick();
    z_cmd_valid = 1'b0;
    repeat (10) tick();
    z_wr_valid = 1'b0;
    check("z_strobe_len", 32'(z_wstb), 32'd1);
    check("z_busy_len", 32'(z_busy_cnt), 32'd4);
    check("z_wrin_len", 32'(z_wrin_cnt), 32'd1);
    check("z_done", 32'(z_done_cnt), 32'd1);
    check("z_addr", 32'(z_addr), 32'h123);
    check("z_data", 32'(z_dat), 32'h5A);
    check("z_rd_idle", 32'({z_rd_valid, z_rd_data}), 32'd0);

    // Whole-run protocol properties
    check("strobe_overlap_or_cs", 32'(ovl_cnt), 32'd0);
    check("stall_bus_idle", 32'(stall_viol), 32'd0);
    check("rd_data_stable", 32'(stab_viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
